// File: rtl/oam_access_arbiter_pkg.sv
// rtl/oam_access_arbiter_pkg.sv - shared OAM widths, FSM states and entry layout
package oam_pkg;

  localparam int OAM_ENTRIES = 64;
  localparam int OAM_INDEX_W = 6;
  localparam int OAM_ADDR_W  = 7;

  typedef enum logic [1:0] {
    IDLE,
    WR_LO,
    WR_HI
  } oam_state_t;

  typedef struct packed {
    logic [15:0] hi;
    logic [15:0] lo;
  } oam_entry_t;

endpackage

// File: rtl/oam_access_arbiter_if.sv
// rtl/oam_access_arbiter_if.sv - CPU, DMA and OAM write-port signals of the arbiter
interface oam_access_arbiter_if;
  import oam_pkg::*;

  logic                   render_active;
  logic                   cpu_req;
  logic [OAM_INDEX_W-1:0] cpu_index;
  logic [31:0]            cpu_entry;
  logic                   cpu_ack;
  logic                   dma_start;
  logic [OAM_INDEX_W-1:0] dma_base;
  logic [6:0]             dma_count;
  logic                   dma_data_valid;
  logic [31:0]            dma_data;
  logic                   dma_data_ready;
  logic                   dma_busy;
  logic                   dma_done;
  logic [OAM_ADDR_W-1:0]  oam_write_addr;
  logic [15:0]            oam_write_data;
  logic                   oam_write_enable;

  modport slave (
    input  render_active, cpu_req, cpu_index, cpu_entry,
    input  dma_start, dma_base, dma_count, dma_data_valid, dma_data,
    output cpu_ack, dma_data_ready, dma_busy, dma_done,
    output oam_write_addr, oam_write_data, oam_write_enable
  );

  modport master (
    output render_active, cpu_req, cpu_index, cpu_entry,
    output dma_start, dma_base, dma_count, dma_data_valid, dma_data,
    input  cpu_ack, dma_data_ready, dma_busy, dma_done,
    input  oam_write_addr, oam_write_data, oam_write_enable
  );

endinterface

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - DMA block-copy bookkeeping: base/count latch, entry index, busy and done
module oam_dma_engine
  import oam_pkg::*;
#(
  parameter int ENTRIES = OAM_ENTRIES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dma_start,
  input  logic [OAM_INDEX_W-1:0] dma_base,
  input  logic [6:0]             dma_count,
  input  logic                   consume,
  input  logic                   entry_done,
  output logic                   busy,
  output logic                   done,
  output logic [OAM_INDEX_W-1:0] index
);

  localparam logic [OAM_INDEX_W-1:0] LAST_INDEX = OAM_INDEX_W'(ENTRIES - 1);

  logic [6:0] remaining_q;

  // remaining_q drops on consume, so it already reads zero during the last entry's WR_HI
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      index       <= '0;
      remaining_q <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (dma_start) begin
          index       <= dma_base;
          remaining_q <= dma_count;
          if (dma_count == 7'd0) begin
            done <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
      end else begin
        if (consume) begin
          index       <= (index == LAST_INDEX) ? '0 : index + 1'b1;
          remaining_q <= remaining_q - 7'd1;
        end
        if (entry_done && (remaining_q == 7'd0)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/oam_access_arbiter.sv
// rtl/oam_access_arbiter.sv - CPU/DMA arbiter writing 32-bit entries as two 16-bit OAM words
// DMA path present only when OAM_DMA_EN is defined; otherwise the CPU is the sole requester.
module oam_access_arbiter
  import oam_pkg::*;
#(
  parameter int ENTRIES  = OAM_ENTRIES,
  parameter bit RR_START = 1'b0
) (
  input logic                clk,
  input logic                reset,
  oam_access_arbiter_if.slave bus
);

  oam_state_t             state_q, state_d;
  logic [OAM_INDEX_W-1:0] index_q;
  oam_entry_t             entry_q;
  logic                   owner_dma_q;
  logic                   rr_q;
  logic                   cpu_elig, dma_elig;
  logic                   grant_cpu, grant_dma;
  logic [OAM_INDEX_W-1:0] dma_idx;
  logic [31:0]            dma_entry;
  logic                   we, ack;
  logic [OAM_ADDR_W-1:0]  addr;
  logic [15:0]            data;

  assign cpu_elig = bus.cpu_req & ~bus.render_active;

`ifdef OAM_DMA_EN
  logic                   dma_busy, dma_done, entry_done;
  logic [OAM_INDEX_W-1:0] dma_index;

  assign entry_done = (state_q == WR_HI) && owner_dma_q;

  oam_dma_engine #(.ENTRIES(ENTRIES)) u_dma (
    .clk        (clk),
    .reset      (reset),
    .dma_start  (bus.dma_start),
    .dma_base   (bus.dma_base),
    .dma_count  (bus.dma_count),
    .consume    (grant_dma),
    .entry_done (entry_done),
    .busy       (dma_busy),
    .done       (dma_done),
    .index      (dma_index)
  );

  assign dma_elig     = dma_busy & bus.dma_data_valid & ~bus.render_active;
  assign dma_idx      = dma_index;
  assign dma_entry    = bus.dma_data;
  assign bus.dma_busy = dma_busy;
  assign bus.dma_done = dma_done;
`else
  logic unused_dma;

  assign unused_dma   = ^{bus.dma_start, bus.dma_base, bus.dma_count,
                          bus.dma_data_valid, bus.dma_data, 7'(ENTRIES)};
  assign dma_elig     = 1'b0;
  assign dma_idx      = '0;
  assign dma_entry    = '0;
  assign bus.dma_busy = 1'b0;
  assign bus.dma_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    we        = 1'b0;
    ack       = 1'b0;
    addr      = '0;
    data      = '0;
    case (state_q)
      IDLE: begin
        grant_dma = dma_elig & (~cpu_elig | rr_q);
        grant_cpu = cpu_elig & ~grant_dma;
        if (grant_cpu || grant_dma) begin
          state_d = WR_LO;
        end
      end
      WR_LO: begin
        we      = 1'b1;
        addr    = {index_q, 1'b0};
        data    = entry_q.lo;
        state_d = WR_HI;
      end
      WR_HI: begin
        we      = 1'b1;
        addr    = {index_q, 1'b1};
        data    = entry_q.hi;
        ack     = ~owner_dma_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // the pointer only moves when both sides actually contended for this slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q     <= '0;
      entry_q     <= '0;
      owner_dma_q <= 1'b0;
      rr_q        <= RR_START;
    end else if (state_q == IDLE) begin
      if (grant_cpu) begin
        index_q     <= bus.cpu_index;
        entry_q     <= bus.cpu_entry;
        owner_dma_q <= 1'b0;
      end else if (grant_dma) begin
        index_q     <= dma_idx;
        entry_q     <= dma_entry;
        owner_dma_q <= 1'b1;
      end
      if (cpu_elig && dma_elig) begin
        rr_q <= ~rr_q;
      end
    end
  end

  assign bus.oam_write_enable = we;
  assign bus.oam_write_addr   = addr;
  assign bus.oam_write_data   = data;
  assign bus.cpu_ack          = ack;
  assign bus.dma_data_ready   = grant_dma;

endmodule

// File: tb/tb_oam_access_arbiter.sv
// tb/tb_oam_access_arbiter.sv - directed-vector bench for oam_access_arbiter
module tb_oam_access_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  oam_access_arbiter_if bus();

  oam_access_arbiter #(.ENTRIES(64), .RR_START(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic [31:0] we, input logic [31:0] addr,
                          input logic [31:0] data);
    check({tag, "_we"}, 32'(bus.oam_write_enable), we);
    if (we != 0) begin
      check({tag, "_addr"}, 32'(bus.oam_write_addr), addr);
      check({tag, "_data"}, 32'(bus.oam_write_data), data);
    end
  endtask

  initial begin
    bus.render_active  = 1'b0;
    bus.cpu_req        = 1'b0;
    bus.cpu_index      = '0;
    bus.cpu_entry      = '0;
    bus.dma_start      = 1'b0;
    bus.dma_base       = '0;
    bus.dma_count      = '0;
    bus.dma_data_valid = 1'b0;
    bus.dma_data       = '0;
    tick();
    tick();

    check_wr("rst", 32'd0, 32'd0, 32'd0);
    check("rst_addr", 32'(bus.oam_write_addr), 32'd0);
    check("rst_data", 32'(bus.oam_write_data), 32'd0);
    check("rst_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_busy", 32'(bus.dma_busy), 32'd0);
    check("rst_done", 32'(bus.dma_done), 32'd0);
    check("rst_ready", 32'(bus.dma_data_ready), 32'd0);
    reset = 1'b0;
    tick();

    // CPU write: index 5, entry AAAA5555
    bus.cpu_req   = 1'b1;
    bus.cpu_index = 6'd5;
    bus.cpu_entry = 32'hAAAA_5555;
    check_wr("cpu_idle", 32'd0, 32'd0, 32'd0);
    tick();
    check_wr("cpu_lo", 32'd1, 32'd10, 32'h5555);
    check("cpu_lo_ack", 32'(bus.cpu_ack), 32'd0);
    tick();
    check_wr("cpu_hi", 32'd1, 32'd11, 32'hAAAA);
    check("cpu_hi_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    tick();
    check_wr("cpu_after", 32'd0, 32'd0, 32'd0);
    check("cpu_after_ack", 32'(bus.cpu_ack), 32'd0);

    // render_active rises during WR_LO: the high half still lands, then grants stall
    bus.cpu_req   = 1'b1;
    bus.cpu_index = 6'd7;
    bus.cpu_entry = 32'h1234_5678;
    tick();
    bus.render_active = 1'b1;
    check_wr("rnd_lo", 32'd1, 32'd14, 32'h5678);
    tick();
    check_wr("rnd_hi", 32'd1, 32'd15, 32'h1234);
    check("rnd_hi_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_index = 6'd8;
    bus.cpu_entry = 32'h0000_BEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_wr("rnd_block", 32'd0, 32'd0, 32'd0);
    end
    bus.render_active = 1'b0;
    tick();
    check_wr("rnd_resume_lo", 32'd1, 32'd16, 32'hBEEF);
    tick();
    check_wr("rnd_resume_hi", 32'd1, 32'd17, 32'h0000);
    check("rnd_resume_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req = 1'b0;
    tick();

    // reset during a CPU WR_LO abandons the entry without an ack
    bus.cpu_req   = 1'b1;
    bus.cpu_index = 6'd9;
    bus.cpu_entry = 32'hCAFE_F00D;
    tick();
    check_wr("crst_lo", 32'd1, 32'd18, 32'hF00D);
    reset = 1'b1;
    #1;
    check("crst_we", 32'(bus.oam_write_enable), 32'd0);
    check("crst_addr", 32'(bus.oam_write_addr), 32'd0);
    check("crst_ack", 32'(bus.cpu_ack), 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    check("crst_ack2", 32'(bus.cpu_ack), 32'd0);
    reset = 1'b0;
    tick();
    check_wr("crst_after", 32'd0, 32'd0, 32'd0);

`ifdef OAM_DMA_EN
    // DMA base 62 count 4 wraps through entries 62, 63, 0, 1
    bus.dma_start = 1'b1;
    bus.dma_base  = 6'd62;
    bus.dma_count = 7'd4;
    tick();
    bus.dma_start = 1'b0;
    check("dma_busy_set", 32'(bus.dma_busy), 32'd1);
    bus.dma_data_valid = 1'b1;
    for (int e = 0; e < 4; e++) begin
      bus.dma_data = 32'(e + 1);
      #1;
      check("dma_ready", 32'(bus.dma_data_ready), 32'd1);
      tick();
      check_wr("dma_lo", 32'd1, 32'(((62 + e) % 64) * 2), 32'(e + 1));
      check("dma_lo_ready", 32'(bus.dma_data_ready), 32'd0);
      tick();
      check_wr("dma_hi", 32'd1, 32'(((62 + e) % 64) * 2 + 1), 32'd0);
      check("dma_hi_busy", 32'(bus.dma_busy), 32'd1);
      check("dma_hi_done", 32'(bus.dma_done), 32'd0);
      tick();
    end
    check("dma_end_done", 32'(bus.dma_done), 32'd1);
    check("dma_end_busy", 32'(bus.dma_busy), 32'd0);
    check("dma_end_ready", 32'(bus.dma_data_ready), 32'd0);
    tick();
    check("dma_done_once", 32'(bus.dma_done), 32'd0);
    check_wr("dma_quiet", 32'd0, 32'd0, 32'd0);
    bus.dma_data_valid = 1'b0;

    // continuous contention, RR_START=0: CPU, DMA, CPU, DMA
    bus.dma_start = 1'b1;
    bus.dma_base  = 6'd10;
    bus.dma_count = 7'd2;
    tick();
    bus.dma_start      = 1'b0;
    bus.cpu_req        = 1'b1;
    bus.cpu_index      = 6'd20;
    bus.dma_data_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      bus.cpu_entry = 32'hC0DE_0000 + 32'(g);
      bus.dma_data  = 32'hD0A0_0000 + 32'(g);
      #1;
      check("rr_ready", 32'(bus.dma_data_ready), 32'(g % 2));
      tick();
      check_wr("rr_lo", 32'd1, (g % 2 == 1) ? 32'(2 * (10 + g / 2)) : 32'd40, 32'(g));
      tick();
      check_wr("rr_hi", 32'd1, (g % 2 == 1) ? 32'(2 * (10 + g / 2) + 1) : 32'd41,
               (g % 2 == 1) ? 32'hD0A0 : 32'hC0DE);
      check("rr_ack", 32'(bus.cpu_ack), 32'((g + 1) % 2));
      tick();
    end
    bus.cpu_req        = 1'b0;
    bus.dma_data_valid = 1'b0;
    #1;
    check("rr_done", 32'(bus.dma_done), 32'd1);
    check("rr_busy", 32'(bus.dma_busy), 32'd0);
    tick();
    check_wr("rr_quiet", 32'd0, 32'd0, 32'd0);

    // reset mid-DMA at WR_LO: no done, busy cleared
    bus.dma_start = 1'b1;
    bus.dma_base  = 6'd3;
    bus.dma_count = 7'd2;
    tick();
    bus.dma_start      = 1'b0;
    bus.dma_data_valid = 1'b1;
    bus.dma_data       = 32'h1234_5678;
    tick();
    check_wr("drst_lo", 32'd1, 32'd6, 32'h5678);
    reset = 1'b1;
    #1;
    check("drst_we", 32'(bus.oam_write_enable), 32'd0);
    check("drst_data", 32'(bus.oam_write_data), 32'd0);
    check("drst_busy", 32'(bus.dma_busy), 32'd0);
    check("drst_done", 32'(bus.dma_done), 32'd0);
    bus.dma_data_valid = 1'b0;
    tick();
    check("drst_done2", 32'(bus.dma_done), 32'd0);
    reset = 1'b0;
    tick();
    check("drst_done3", 32'(bus.dma_done), 32'd0);
    check("drst_busy3", 32'(bus.dma_busy), 32'd0);

    // count 0: done one cycle after start, no writes
    bus.dma_start = 1'b1;
    bus.dma_base  = 6'd5;
    bus.dma_count = 7'd0;
    tick();
    bus.dma_start = 1'b0;
    check("zero_done", 32'(bus.dma_done), 32'd1);
    check("zero_busy", 32'(bus.dma_busy), 32'd0);
    check_wr("zero_nowr", 32'd0, 32'd0, 32'd0);
    tick();
    check("zero_done2", 32'(bus.dma_done), 32'd0);
    check_wr("zero_nowr2", 32'd0, 32'd0, 32'd0);
`else
    // DMA path absent: its outputs stay low and its inputs are ignored
    bus.dma_start      = 1'b1;
    bus.dma_base       = 6'd2;
    bus.dma_count      = 7'd4;
    bus.dma_data_valid = 1'b1;
    bus.dma_data       = 32'h5A5A_5A5A;
    #1;
    check("nodma_ready", 32'(bus.dma_data_ready), 32'd0);
    tick();
    bus.dma_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("nodma_busy", 32'(bus.dma_busy), 32'd0);
      check("nodma_done", 32'(bus.dma_done), 32'd0);
      check("nodma_ready2", 32'(bus.dma_data_ready), 32'd0);
      check_wr("nodma_nowr", 32'd0, 32'd0, 32'd0);
      tick();
    end
    bus.cpu_req   = 1'b1;
    bus.cpu_index = 6'd63;
    bus.cpu_entry = 32'h0F0F_F0F0;
    tick();
    check_wr("nodma_cpu_lo", 32'd1, 32'd126, 32'hF0F0);
    tick();
    check_wr("nodma_cpu_hi", 32'd1, 32'd127, 32'h0F0F);
    check("nodma_cpu_ack", 32'(bus.cpu_ack), 32'd1);
    bus.cpu_req        = 1'b0;
    bus.dma_data_valid = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
